fp_compare_pipe: RTL

- Parametrised, pipelined comparator for FloPoCo-format floats: 2-bit exception field, then sign, WE-bit exponent, WF-bit fraction.
- Produces lt/eq/gt/unordered flags, a mode-selected boolean result, and min/max of the two operands with fixed 2-cycle latency and valid/tag tracking.
- Used in the ray-AABB datapath for slab interval tests (tnear = max of mins, tfar = min of maxes, hit = tnear LE tfar).
- Needs no subtractor and has no exponent-alignment latency.

---
 rtl/fp_pkg.sv | 66 ++++++
 rtl/fp_mag_key.sv | 37 +++
 rtl/fp_compare_pipe.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fp_pkg                                                       |
// | Description : Shared constants and helpers for FloPoCo-format floats.      |
// |               Operand layout (MSB..LSB): exc[1:0], sign, exp[WE-1:0],      |
// |               frac[WF-1:0]. Field positions and canonical encodings are    |
// |               functions of WE/WF so every parametrisation shares one       |
// |               definition.                                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package fp_pkg;

   // Exception field encodings
   localparam logic [1:0] EXC_ZERO = 2'b00;
   localparam logic [1:0] EXC_NORM = 2'b01;
   localparam logic [1:0] EXC_INF  = 2'b10;
   localparam logic [1:0] EXC_NAN  = 2'b11;

   // Comparison predicates; 3'b110 and 3'b111 are reserved and yield 0
   localparam logic [2:0] CMP_GT = 3'b000;
   localparam logic [2:0] CMP_GE = 3'b001;
   localparam logic [2:0] CMP_LT = 3'b010;
   localparam logic [2:0] CMP_LE = 3'b011;
   localparam logic [2:0] CMP_EQ = 3'b100;
   localparam logic [2:0] CMP_NE = 3'b101;

   // Widest operand the canonical-value constructors can build
   localparam int MAX_W = 64;

   function automatic int fp_width(input int we, input int wf);
      return we + wf + 3;
   endfunction

   // LSB of the 2-bit exception field
   function automatic int exc_lsb(input int we, input int wf);
      return we + wf + 1;
   endfunction

   function automatic int sign_pos(input int we, input int wf);
      return we + wf;
   endfunction

   // LSB of the exponent field (the fraction occupies [wf-1:0])
   function automatic int exp_lsb(input int we, input int wf);
      return wf + 0 * we;
   endfunction

   // Canonical NaN: exception 11, sign/exp/frac all zero
   function automatic logic [MAX_W-1:0] canon_nan(input int we, input int wf);
      logic [MAX_W-1:0] v;
      v = '0;
      v[exc_lsb(we, wf) +: 2] = EXC_NAN;
      return v;
   endfunction

   // Canonical signed zero: exception 00, exp/frac zero, requested sign
   function automatic logic [MAX_W-1:0] canon_zero(input int we, input int wf, input logic neg);
      logic [MAX_W-1:0] v;
      v = '0;
      v[exc_lsb(we, wf) +: 2] = EXC_ZERO;
      v[sign_pos(we, wf)]     = neg;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mag_key.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_mag_key                                                   |
// | Description : Combinational magnitude key {exc, exp, frac}. Exponent and   |
// |               fraction are zeroed for zero and infinity so that any junk   |
// |               payload in those encodings cannot affect ordering; the key   |
// |               then orders magnitudes with a plain unsigned compare.        |
// | Ports       : exc  [1:0]       exception field                            |
// |               expo [WE-1:0]    exponent field                             |
// |               frac [WF-1:0]    fraction field                             |
// |               key  [WE+WF+1:0] magnitude key                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fp_mag_key
   import fp_pkg::*;
#(
   parameter int WE = 11,
   parameter int WF = 17
) (
   input  logic [1:0]       exc,
   input  logic [WE-1:0]    expo,
   input  logic [WF-1:0]    frac,
   output logic [WE+WF+1:0] key
);

   logic keep_fields;

   always_comb begin
      // Zero and infinity carry no magnitude information in exp/frac.
      keep_fields = !((exc == EXC_ZERO) || (exc == EXC_INF));
      key         = {exc,
                     keep_fields ? expo : {WE{1'b0}},
                     keep_fields ? frac : {WF{1'b0}}};
   end

endmodule
`default_nettype wire

// File: rtl/fp_compare_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_compare_pipe                                              |
// | Description : Two-stage pipelined comparator for FloPoCo floats. Produces  |
// |               lt/eq/gt/unordered, a mode-selected predicate and min/max of |
// |               the operands. No subtractor: ordering comes from an unsigned |
// |               compare of magnitude keys plus sign resolution.              |
// | Ports       : clk, rst (sync, active high), ce (global pipeline enable)    |
// |               in_valid, inA, inB, mode[2:0], tag_in[TW-1:0]  -> stage 1    |
// |               out_valid, result, lt, eq, gt, unordered,                    |
// |               max_out, min_out, tag_out[TW-1:0]              <- stage 2    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fp_compare_pipe
   import fp_pkg::*;
#(
   parameter int WE = 11,
   parameter int WF = 17,
   parameter int TW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             in_valid,
   input  logic [WE+WF+2:0] inA,
   input  logic [WE+WF+2:0] inB,
   input  logic [2:0]       mode,
   input  logic [TW-1:0]    tag_in,
   output logic             out_valid,
   output logic             result,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic             unordered,
   output logic [WE+WF+2:0] max_out,
   output logic [WE+WF+2:0] min_out,
   output logic [TW-1:0]    tag_out
);

   localparam int W        = fp_width(WE, WF);
   localparam int KW       = WE + WF + 2;
   localparam int EXC_LSB  = exc_lsb(WE, WF);
   localparam int SIGN_BIT = sign_pos(WE, WF);
   localparam int EXP_LSB  = exp_lsb(WE, WF);

   localparam logic [W-1:0] NAN_C      = W'(canon_nan(WE, WF));
   localparam logic [W-1:0] ZERO_POS_C = W'(canon_zero(WE, WF, 1'b0));
   localparam logic [W-1:0] ZERO_NEG_C = W'(canon_zero(WE, WF, 1'b1));

   // ---------------------------------------------------------------- stage 1
   logic [1:0]    exc_a;
   logic [1:0]    exc_b;
   logic [KW-1:0] key_a;
   logic [KW-1:0] key_b;

   assign exc_a = inA[EXC_LSB +: 2];
   assign exc_b = inB[EXC_LSB +: 2];

   fp_mag_key #(.WE(WE), .WF(WF)) u_key_a (
      .exc  (exc_a),
      .expo (inA[EXP_LSB +: WE]),
      .frac (inA[WF-1:0]),
      .key  (key_a)
   );

   fp_mag_key #(.WE(WE), .WF(WF)) u_key_b (
      .exc  (exc_b),
      .expo (inB[EXP_LSB +: WE]),
      .frac (inB[WF-1:0]),
      .key  (key_b)
   );

   logic          s1_valid;
   logic          s1_kmag_eq;
   logic          s1_kmag_gt;
   logic          s1_sign_a;
   logic          s1_sign_b;
   logic          s1_nan_a;
   logic          s1_nan_b;
   logic          s1_both_zero;
   logic [2:0]    s1_mode;
   logic [TW-1:0] s1_tag;
   logic [W-1:0]  s1_a;
   logic [W-1:0]  s1_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_kmag_eq   <= 1'b0;
         s1_kmag_gt   <= 1'b0;
         s1_sign_a    <= 1'b0;
         s1_sign_b    <= 1'b0;
         s1_nan_a     <= 1'b0;
         s1_nan_b     <= 1'b0;
         s1_both_zero <= 1'b0;
         s1_mode      <= 3'b000;
         s1_tag       <= '0;
         s1_a         <= '0;
         s1_b         <= '0;
      end else if (ce) begin
         s1_valid     <= in_valid;
         s1_kmag_eq   <= (key_a == key_b);
         s1_kmag_gt   <= (key_a > key_b);
         s1_sign_a    <= inA[SIGN_BIT];
         s1_sign_b    <= inB[SIGN_BIT];
         s1_nan_a     <= (exc_a == EXC_NAN);
         s1_nan_b     <= (exc_b == EXC_NAN);
         s1_both_zero <= (exc_a == EXC_ZERO) && (exc_b == EXC_ZERO);
         s1_mode      <= mode;
         s1_tag       <= tag_in;
         s1_a         <= inA;
         s1_b         <= inB;
      end
   end

   // ------------------------------------------------- stage 2 combinational
   logic         cmp_unord;
   logic         cmp_eq;
   logic         cmp_gt;
   logic         cmp_lt;
   logic         cmp_result;
   logic [W-1:0] sel_max;
   logic [W-1:0] sel_min;

   always_comb begin
      cmp_unord = s1_nan_a | s1_nan_b;

      // Signed zeros compare equal whatever their sign bits.
      cmp_eq = !cmp_unord &
               (s1_both_zero | (s1_kmag_eq & (s1_sign_a == s1_sign_b)));

      // Positive beats negative; among negatives the smaller magnitude wins.
      cmp_gt = !cmp_unord & !cmp_eq &
               ((!s1_sign_a &  s1_sign_b) |
                (!s1_sign_a & !s1_sign_b &  s1_kmag_gt) |
                ( s1_sign_a &  s1_sign_b & !s1_kmag_gt & !s1_kmag_eq));

      cmp_lt = !cmp_unord & !cmp_eq & !cmp_gt;

      case (s1_mode)
         CMP_GT:  cmp_result = cmp_gt;
         CMP_GE:  cmp_result = cmp_gt | cmp_eq;
         CMP_LT:  cmp_result = cmp_lt;
         CMP_LE:  cmp_result = cmp_lt | cmp_eq;
         CMP_EQ:  cmp_result = cmp_eq;
         CMP_NE:  cmp_result = !cmp_eq;
         default: cmp_result = 1'b0;
      endcase

      sel_max = s1_a;
      sel_min = s1_a;
      if (s1_nan_a && s1_nan_b) begin
         sel_max = NAN_C;
         sel_min = NAN_C;
      end else if (s1_nan_a) begin
         // A single NaN is ignored so that slab min/max keep the real bound.
         sel_max = s1_b;
         sel_min = s1_b;
      end else if (s1_nan_b) begin
         sel_max = s1_a;
         sel_min = s1_a;
      end else if (cmp_eq && s1_both_zero) begin
         sel_max = ZERO_POS_C;
         sel_min = ZERO_NEG_C;
      end else if (cmp_eq) begin
         sel_max = s1_a;
         sel_min = s1_a;
      end else if (cmp_gt) begin
         sel_max = s1_a;
         sel_min = s1_b;
      end else begin
         sel_max = s1_b;
         sel_min = s1_a;
      end
   end

   // ---------------------------------------------------------------- stage 2
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= 1'b0;
         lt        <= 1'b0;
         eq        <= 1'b0;
         gt        <= 1'b0;
         unordered <= 1'b0;
         max_out   <= '0;
         min_out   <= '0;
         tag_out   <= '0;
      end else if (ce) begin
         out_valid <= s1_valid;
         result    <= cmp_result;
         lt        <= cmp_lt;
         eq        <= cmp_eq;
         gt        <= cmp_gt;
         unordered <= cmp_unord;
         max_out   <= sel_max;
         min_out   <= sel_min;
         tag_out   <= s1_tag;
      end
   end

endmodule
`default_nettype wire
